// File: rtl/str_bus_word_sink_pkg.sv
// str_bus_pkg: shared widths, entry type and assembler state for the simple_bus word sink.
package str_bus_pkg;
  localparam int BYTE_W = 8;
  function automatic int word_w(int nbytes);
    return nbytes * BYTE_W;
  endfunction
  typedef struct packed {
    logic [word_w(8)-1:0] data;
    logic [3:0] nbytes;
  } word_entry_t;
  typedef enum logic {ACCEPT, HOLD} asm_state_t;
endpackage

// File: rtl/str_bus_word_sink_if.sv
// simple_bus: byte stream with valid/ready handshake.
interface simple_bus;
  import str_bus_pkg::*;
  logic [BYTE_W-1:0] data;
  logic valid;
  logic ready;
  modport master(output data, output valid, input ready);
  modport slave(input data, input valid, output ready);
endinterface

// File: rtl/str_bus_word_sink_fifo.sv
// str_sync_fifo: generic synchronous FIFO over any entry type with full/empty/count.
module str_sync_fifo #(
  parameter type T = logic [7:0],
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  T              din,
  input  logic          pop,
  output T              dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  T mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr, rd;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign wr = push && (!full || pop);
  assign rd = pop && !empty;
  assign dout = mem[rp];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (wr) begin
        mem[wp] <= din;
        wp <= wp + 1'b1;
      end
      if (rd) rp <= rp + 1'b1;
      count <= count + CW'(wr) - CW'(rd);
    end
  end
endmodule

// File: rtl/str_bus_word_sink.sv
// str_bus_word_sink: packs simple_bus bytes little-endian into words and queues them for a consumer.
// Define STR_WORD_SINK_STATS_EN to add byte_total and stall_cycles counters.
module str_bus_word_sink
  import str_bus_pkg::*;
#(
  parameter int WORD_BYTES = 4,
  parameter int DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  simple_bus.slave                           bus_in,
  input  logic                               flush,
  output logic [word_w(WORD_BYTES)-1:0]      word_data,
  output logic [$clog2(WORD_BYTES+1)-1:0]    word_nbytes,
  output logic                               word_valid,
  input  logic                               word_ready,
  output logic [$clog2(DEPTH+1)-1:0]         fifo_count
`ifdef STR_WORD_SINK_STATS_EN
  ,
  output logic [31:0]                        byte_total,
  output logic [15:0]                        stall_cycles
`endif
);
  localparam int WW = word_w(WORD_BYTES);
  localparam int NBW = $clog2(WORD_BYTES + 1);
  typedef struct packed {
    logic [WW-1:0] data;
    logic [NBW-1:0] nbytes;
  } entry_t;
  asm_state_t st, st_d;
  logic [NBW-1:0] byte_cnt, cnt_d, new_cnt;
  logic [WW-1:0] asm_q, asm_d, new_asm;
  logic rst_q, acc, push, full, empty, flush_hit;
  entry_t din, head;
  assign acc = bus_in.valid && bus_in.ready;
  // ready depends only on registered state, never on word_ready
  assign bus_in.ready = !rst_q && st == ACCEPT && (byte_cnt != NBW'(WORD_BYTES - 1) || !full);
  always_comb begin
    new_asm = asm_q;
    if (acc) new_asm[int'(byte_cnt)*BYTE_W +: BYTE_W] = bus_in.data;
    new_cnt = byte_cnt + NBW'(acc);
    flush_hit = flush && new_cnt != '0;
    push = st == HOLD ? !full : (new_cnt == NBW'(WORD_BYTES)) || (flush_hit && !full);
    st_d = st == HOLD ? (full ? HOLD : ACCEPT) : (flush_hit && !push ? HOLD : ACCEPT);
    cnt_d = push ? '0 : new_cnt;
    asm_d = push ? '0 : new_asm;
  end
  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      st <= ACCEPT;
      byte_cnt <= '0;
      asm_q <= '0;
    end else begin
      st <= st_d;
      byte_cnt <= cnt_d;
      asm_q <= asm_d;
    end
  end
  assign din = '{data: new_asm, nbytes: new_cnt};
  str_sync_fifo #(.T(entry_t), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .din(din),
    .pop(word_ready),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(fifo_count)
  );
  assign word_valid = !empty;
  assign word_data = word_valid ? head.data : '0;
  assign word_nbytes = word_valid ? head.nbytes : '0;
`ifdef STR_WORD_SINK_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_total <= '0;
      stall_cycles <= '0;
    end else begin
      if (acc) byte_total <= byte_total + 1'b1;
      if (bus_in.valid && !bus_in.ready && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_str_bus_word_sink.sv
// tb_str_bus_word_sink: scoreboard bench for str_bus_word_sink (WORD_BYTES=4, DEPTH=4).
module tb_str_bus_word_sink;
  typedef struct packed {
    logic [31:0] d;
    logic [2:0] n;
  } exp_t;
  logic clk = 0, rst = 1, flush = 0, word_ready = 0;
  logic [31:0] word_data;
  logic [2:0] word_nbytes, fifo_count;
  logic word_valid;
`ifdef STR_WORD_SINK_STATS_EN
  logic [31:0] byte_total;
  logic [15:0] stall_cycles;
`endif
  int tests = 0, fails = 0;
  exp_t exp_q[$];
  logic [31:0] m_asm = 0;
  int m_cnt = 0;
  simple_bus bus();
  always #5 clk = ~clk;
  str_bus_word_sink #(.WORD_BYTES(4), .DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus_in(bus),
    .flush(flush),
    .word_data(word_data),
    .word_nbytes(word_nbytes),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .fifo_count(fifo_count)
`ifdef STR_WORD_SINK_STATS_EN
    ,
    .byte_total(byte_total),
    .stall_cycles(stall_cycles)
`endif
  );
  always @(negedge clk) begin
    if (!rst && word_valid && word_ready) begin
      exp_t e;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL pop_unexpected: got data=%h nbytes=%0d, expected no word", word_data, word_nbytes);
      end else begin
        e = exp_q.pop_front();
        if ({word_data, word_nbytes} !== e) begin
          fails++;
          $display("FAIL word_pop: got data=%h nbytes=%0d, expected data=%h nbytes=%0d", word_data, word_nbytes, e.d, e.n);
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic model_push();
    exp_q.push_back('{d: m_asm, n: 3'(m_cnt)});
    m_asm = 0;
    m_cnt = 0;
  endtask
  task automatic send_byte(input logic [7:0] d, input bit fl);
    int waited = 0;
    bit ok = 0;
    bus.valid = 1;
    bus.data = d;
    flush = fl;
    while (!ok && waited < 500) begin
      @(negedge clk);
      if (bus.ready) ok = 1;
      else waited++;
    end
    if (ok) begin
      m_asm[m_cnt*8 +: 8] = d;
      m_cnt++;
      if (m_cnt == 4 || fl) model_push();
    end else begin
      tests++;
      fails++;
      $display("FAIL send_timeout: byte %h not accepted after %0d cycles, expected acceptance", d, waited);
    end
    tick();
    bus.valid = 0;
    flush = 0;
  endtask
  task automatic flush_only();
    flush = 1;
    if (m_cnt > 0) model_push();
    tick();
    flush = 0;
  endtask
  task automatic wait_drain(input string name);
    int n = 0;
    word_ready = 1;
    while ((exp_q.size() != 0 || word_valid) && n < 200) begin
      tick();
      n++;
    end
    tests++;
    if (exp_q.size() != 0 || word_valid !== 0 || fifo_count !== 0) begin
      fails++;
      $display("FAIL %s_drain: got pending=%0d valid=%b count=%0d, expected 0/0/0", name, exp_q.size(), word_valid, fifo_count);
    end
  endtask
  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    tests++;
    if (bus.ready !== 0 || word_valid !== 0 || word_data !== 0 || word_nbytes !== 0 || fifo_count !== 0) begin
      fails++;
      $display("FAIL reset_state: got ready=%b valid=%b data=%h nb=%0d cnt=%0d, expected all 0", bus.ready, word_valid, word_data, word_nbytes, fifo_count);
    end
    tick();
    tests++;
    if (bus.ready !== 1) begin
      fails++;
      $display("FAIL reset_ready: got %b, expected 1", bus.ready);
    end
  endtask
  task automatic test_stream();
    word_ready = 1;
    for (int i = 1; i <= 3; i++) send_byte(8'(i * 8'h11), 0);
    tests++;
    if (word_valid !== 0) begin
      fails++;
      $display("FAIL stream_early: got valid=%b, expected 0", word_valid);
    end
    send_byte(8'h44, 0);
    tests++;
    if (word_valid !== 1 || word_data !== 32'h44332211 || word_nbytes !== 3'd4) begin
      fails++;
      $display("FAIL stream_latency: got valid=%b data=%h nb=%0d, expected 1/44332211/4", word_valid, word_data, word_nbytes);
    end
    for (int i = 5; i <= 8; i++) send_byte(8'(i * 8'h11), 0);
    wait_drain("stream");
  endtask
  task automatic test_backpressure();
    word_ready = 0;
    for (int i = 0; i < 19; i++) send_byte(8'(8'h30 + i), 0);
    bus.valid = 1;
    bus.data = 8'h43;
    repeat (3) @(negedge clk);
    tests++;
    if (bus.ready !== 0 || fifo_count !== 3'd4) begin
      fails++;
      $display("FAIL bp_stall: got ready=%b count=%0d, expected 0/4", bus.ready, fifo_count);
    end
    tick();
    word_ready = 1;
    send_byte(8'h43, 0);
    wait_drain("bp");
  endtask
  task automatic test_flush();
    word_ready = 1;
    send_byte(8'hA1, 0);
    send_byte(8'hB2, 0);
    send_byte(8'hC3, 0);
    flush_only();
    send_byte(8'hD4, 0);
    flush_only();
    wait_drain("flush");
  endtask
  task automatic test_flush_same_cycle();
    word_ready = 1;
    send_byte(8'h01, 0);
    send_byte(8'h02, 1);
    wait_drain("flush_same");
    flush_only();
    tests++;
    if (word_valid !== 0 || fifo_count !== 0) begin
      fails++;
      $display("FAIL flush_empty: got valid=%b count=%0d, expected 0/0", word_valid, fifo_count);
    end
  endtask
  task automatic test_flush_pending();
    word_ready = 0;
    for (int i = 0; i < 18; i++) send_byte(8'(8'h60 + i), 0);
    flush_only();
    @(negedge clk);
    tests++;
    if (bus.ready !== 0 || fifo_count !== 3'd4) begin
      fails++;
      $display("FAIL flush_pending: got ready=%b count=%0d, expected 0/4", bus.ready, fifo_count);
    end
    tick();
    wait_drain("pending");
    tests++;
    if (bus.ready !== 1) begin
      fails++;
      $display("FAIL pending_release: got ready=%b, expected 1", bus.ready);
    end
  endtask
  task automatic test_reset_mid_word();
    word_ready = 0;
    for (int i = 0; i < 10; i++) send_byte(8'(8'h90 + i), 0);
    rst = 1;
    tick();
    rst = 0;
    exp_q.delete();
    m_asm = 0;
    m_cnt = 0;
    tests++;
    if (word_valid !== 0 || fifo_count !== 0) begin
      fails++;
      $display("FAIL reset_mid: got valid=%b count=%0d, expected 0/0", word_valid, fifo_count);
    end
    for (int i = 0; i < 4; i++) send_byte(8'(8'h5A + i), 0);
    wait_drain("reset_mid");
  endtask
`ifdef STR_WORD_SINK_STATS_EN
  task automatic test_stats();
    rst = 1;
    tick();
    rst = 0;
    tick();
    tests++;
    if (byte_total !== 0 || stall_cycles !== 0) begin
      fails++;
      $display("FAIL stats_reset: got total=%0d stall=%0d, expected 0/0", byte_total, stall_cycles);
    end
    word_ready = 0;
    for (int i = 0; i < 19; i++) send_byte(8'(8'hC0 + i), 0);
    bus.valid = 1;
    repeat (5) @(posedge clk);
    #1;
    bus.valid = 0;
    tests++;
    if (byte_total !== 32'd19 || stall_cycles !== 16'd5) begin
      fails++;
      $display("FAIL stats_count: got total=%0d stall=%0d, expected 19/5", byte_total, stall_cycles);
    end
    bus.valid = 1;
    repeat (70000) @(posedge clk);
    #1;
    bus.valid = 0;
    tests++;
    if (stall_cycles !== 16'hFFFF) begin
      fails++;
      $display("FAIL stats_saturate: got stall=%h, expected ffff", stall_cycles);
    end
    flush_only();
    wait_drain("stats");
  endtask
`endif
  initial begin
    bus.valid = 0;
    bus.data = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_flush_same_cycle();
    test_flush_pending();
    test_reset_mid_word();
`ifdef STR_WORD_SINK_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
